window_linebuffer: RTL and testbench
====================================

Name: window_linebuffer

Overview:
Streaming K×K sliding-window generator for the convolution datapath.
- Accepts one raster-order pixel per handshake from the feature-map source.
- Holds K-1 full line delays internally.
- Presents a complete K×K neighbourhood with its output coordinates to the downstream MAC array.
- Parametrised in pixel width, image width/height and kernel size. Adds valid/ready flow control, frame tracking and edge masking.

Parameters:
- BIT_DEPTH, 8, pixel width in bits.
- COLS, 28, image width in pixels (≥ K).
- ROWS, 28, image height in pixels (≥ K).
- K, 3, kernel/window size (2..7).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_data  in  BIT_DEPTH  input pixel, raster order.
- flush  in  1  synchronous restart of frame position; line contents not cleared.
- win_valid  out  1  window valid.
- win_ready  in  1  downstream accepts the window.
- win_data  out  K*K*BIT_DEPTH  window, element (r,c) at bits [(r*K+c)*BIT_DEPTH +: BIT_DEPTH]; r=0 oldest (top) row, c=0 leftmost column.
- win_row  out  clog2(ROWS)  output row of window top-left = pixel row − (K−1).
- win_col  out  clog2(COLS)  output column of window top-left = pixel col − (K−1).
- frame_done  out  1  one-cycle pulse: last pixel of a frame accepted.

Behaviour:
- Reset, asynchronous on rst_n low:
  - col/row counters = 0.
  - win_valid = 0, win_data = 0, win_row = win_col = 0, frame_done = 0.
  - Line-delay storage is not reset; stale contents are masked by the counters.
- Accept: acc = in_valid && in_ready.
  - in_ready = !win_valid || win_ready, combinational; no skid buffer.
- On acc:
  - Pixel enters window column K-1 of row K-1.
  - Window columns shift left.
  - Each line delay advances by one entry; line delay i feeds window row i.
  - Delay depth is exactly COLS, so window row r holds pixels from image row (cur_row − (K−1−r)).
- Counters:
  - col increments on acc, wraps COLS-1 → 0 and increments row.
  - row wraps ROWS-1 → 0.
  - frame_done = 1 on the cycle after the acc of pixel (ROWS-1, COLS-1); otherwise 0.
- Window valid and latency:
  - win_valid is set on the edge following acc when row ≥ K-1 and col ≥ K-1 for the accepted pixel. Latency is 1 cycle.
  - win_data, win_row and win_col are registered with it.
  - Accepted pixels in the masked region (row < K-1 or col < K-1) clear win_valid if the previous window was consumed.
  - The window never spans a row wrap: windows for col < K-1 are suppressed, not emitted.
- Output handshake:
  - win_valid is cleared on a win_valid && win_ready edge unless a new valid window is produced on the same edge.
  - While win_valid && !win_ready, all of win_* are held stable and in_ready = 0.
- Window count: each frame emits exactly (ROWS−K+1)·(COLS−K+1) windows, in raster order.
- flush:
  - Counters → 0, win_valid → 0, frame_done → 0 on the next edge.
  - flush has priority over a simultaneous acc; that pixel is dropped.
- Reset mid-frame: next accepted pixel is treated as (0,0). No window is emitted until K-1 fresh rows have filled.
- Arithmetic: none on pixel values; data passes bit-exact, unsigned.
- Counter widths are clog2(COLS) / clog2(ROWS). Wrap compares against COLS-1 / ROWS-1, never a power of two.

Optional Feature:
- Macro: WINDOW_LB_STRIDE2_EN.
- Defined: stride 2. A window is emitted only when (row−(K−1)) and (col−(K−1)) are both even.
  - win_row/win_col report the strided index, i.e. divided by 2.
  - Per frame: floor((ROWS−K)/2+1)·floor((COLS−K)/2+1) windows.
  - Line-delay and counter behaviour are unchanged.
- Undefined: stride 1 as described above.

Test Plan:
- Fill and first window. K=3, COLS=4, ROWS=4; stream pixels p=row*4+col+1 with in_valid held high and win_ready held high.
  - First win_valid one cycle after pixel 11 is accepted.
  - win_data rows = {1,2,3},{5,6,7},{9,10,11}; win_row=0, win_col=0.
- Full frame, same setup.
  - Exactly 4 windows, with (win_row,win_col) = (0,0),(0,1),(1,0),(1,1).
  - Last window = {6,7,8},{10,11,12},{14,15,16}.
  - frame_done pulses once, the cycle after pixel 16 is accepted.
- Backpressure. Hold win_ready=0 for 5 cycles on the first window.
  - in_ready=0 throughout; win_data stays {1,2,3,5,6,7,9,10,11}.
  - No pixel is lost; the remaining windows match the free-flowing run.
- Back-to-back frames. Stream 2 frames with no gap.
  - The second frame emits the same 4 windows.
  - No window mixes rows across the frame boundary: the first window of frame 2 appears only after its pixel (2,2) is accepted.
- Reset/flush mid-frame. Assert rst_n=0 (async, mid-cycle) after pixel 7, then restart the stream at p=1.
  - win_valid=0 immediately.
  - The first window again appears after the new pixel 11, with the expected contents.
  - Repeat the check with flush instead of reset.
- Stride option, with WINDOW_LB_STRIDE2_EN, K=3, COLS=ROWS=5.
  - Exactly 4 windows at strided (0,0),(0,1),(1,0),(1,1).
  - Their top-left pixels are 1, 3, 11, 13.

Source files
------------

// File: rtl/window_linebuffer.sv
// window_linebuffer: streaming KxK sliding-window generator.
//
// Pixels arrive in raster order. K-1 line delays of depth COLS feed window rows 0..K-2,
// and the live pixel feeds row K-1. A window is registered whenever the accepted pixel
// completes a full KxK neighbourhood inside the current row band. Windows are not
// emitted for col < K-1, so they never straddle a row wrap.
//
// Optional build macro: WINDOW_LB_STRIDE2_EN. When it is defined, stride 2 is used:
// only windows with an even top-left row and column are emitted, and win_row/win_col
// give the strided index.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    pixel handshake; in_ready = !win_valid || win_ready
//   in_data              pixel, BIT_DEPTH bits
//   flush                synchronous frame-position restart (dominates accept)
//   win_valid/win_ready  window handshake
//   win_data             element (r,c) at [(r*K+c)*BIT_DEPTH +: BIT_DEPTH], r=0 is the top row
//   win_row/win_col      top-left coordinate of the window
//   frame_done           one-cycle pulse after the last pixel of a frame is accepted
module window_linebuffer #(
   parameter int unsigned BIT_DEPTH = 8,
   parameter int unsigned COLS      = 28,
   parameter int unsigned ROWS      = 28,
   parameter int unsigned K         = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [BIT_DEPTH-1:0]         in_data,
   input  logic                         flush,
   output logic                         win_valid,
   input  logic                         win_ready,
   output logic [K*K*BIT_DEPTH-1:0]     win_data,
   output logic [$clog2(ROWS)-1:0]      win_row,
   output logic [$clog2(COLS)-1:0]      win_col,
   output logic                         frame_done
);

   localparam int unsigned ColW = $clog2(COLS);
   localparam int unsigned RowW = $clog2(ROWS);
   localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(ROWS - 1);
   localparam logic [ColW-1:0] ColOff  = ColW'(K - 1);
   localparam logic [RowW-1:0] RowOff  = RowW'(K - 1);

   logic [ColW-1:0]      col_q, col_d;
   logic [RowW-1:0]      row_q, row_d;
   logic                 win_valid_q, win_valid_d;
   logic [RowW-1:0]      win_row_q, win_row_d;
   logic [ColW-1:0]      win_col_q, win_col_d;
   logic                 frame_done_q, frame_done_d;
   logic [BIT_DEPTH-1:0] win_q [K][K];

   // Line delays are addressed by the column counter, so each entry is read exactly
   // COLS accepts after it was written. They are not reset.
   logic [BIT_DEPTH-1:0] line_mem [K-1][COLS];
   logic [BIT_DEPTH-1:0] tap [K];

   logic            acc, take, emit, in_window;
   logic            col_last, row_last;
   logic [ColW-1:0] col_diff;
   logic [RowW-1:0] row_diff;

   assign in_ready = !win_valid_q || win_ready;
   assign acc      = in_valid && in_ready;
   assign take     = acc && !flush;  // flush drops a coincident pixel
   assign col_last = (col_q == ColLast);
   assign row_last = (row_q == RowLast);
   assign col_diff = col_q - ColOff;
   assign row_diff = row_q - RowOff;
   assign in_window = (row_q >= RowOff) && (col_q >= ColOff);

`ifdef WINDOW_LB_STRIDE2_EN
   assign emit      = in_window && !row_diff[0] && !col_diff[0];
   assign win_row_d = row_diff >> 1;
   assign win_col_d = col_diff >> 1;
`else
   assign emit      = in_window;
   assign win_row_d = row_diff;
   assign win_col_d = col_diff;
`endif

   always_comb begin
      for (int i = 0; i < int'(K); i++) tap[i] = '0;
      for (int i = 0; i < int'(K) - 1; i++) tap[i] = line_mem[i][col_q];
      tap[K-1] = in_data;
   end

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (flush) begin
         col_d = '0;
         row_d = '0;
      end else if (acc) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
      end
   end

   always_comb begin
      win_valid_d = win_valid_q;
      if (flush) begin
         win_valid_d = 1'b0;
      end else if (take) begin
         win_valid_d = emit;
      end else if (win_ready) begin
         win_valid_d = 1'b0;
      end
      frame_done_d = take && col_last && row_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
         for (int r = 0; r < int'(K); r++) begin
            for (int c = 0; c < int'(K); c++) win_q[r][c] <= '0;
         end
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         if (take && emit) begin
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
         end
         // Window registers only move on a real accept, so a stalled window holds.
         if (take) begin
            for (int r = 0; r < int'(K); r++) begin
               for (int c = 0; c < int'(K) - 1; c++) win_q[r][c] <= win_q[r][c+1];
               win_q[r][K-1] <= tap[r];
            end
         end
      end
   end

   // Each line delay hands its oldest entry to the one above it.
   always_ff @(posedge clk) begin
      if (take) begin
         line_mem[K-2][col_q] <= in_data;
         for (int i = 0; i < int'(K) - 2; i++) line_mem[i][col_q] <= line_mem[i+1][col_q];
      end
   end

   always_comb begin
      win_data = '0;
      for (int r = 0; r < int'(K); r++) begin
         for (int c = 0; c < int'(K); c++) begin
            win_data[(r*int'(K)+c)*int'(BIT_DEPTH) +: BIT_DEPTH] = win_q[r][c];
         end
      end
   end

   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_linebuffer.sv
// tb_window_linebuffer: scoreboard bench for window_linebuffer (K=3). Builds with
// COLS=ROWS=4, or with COLS=ROWS=5 when WINDOW_LB_STRIDE2_EN is defined.
module tb_window_linebuffer;

   localparam int BD = 8;
   localparam int K  = 3;
`ifdef WINDOW_LB_STRIDE2_EN
   localparam int COLS   = 5;
   localparam int ROWS   = 5;
   localparam int STRIDE = 2;
`else
   localparam int COLS   = 4;
   localparam int ROWS   = 4;
   localparam int STRIDE = 1;
`endif
   localparam int RW    = $clog2(ROWS);
   localparam int CW    = $clog2(COLS);
   localparam int NPIX  = ROWS * COLS;
   localparam int NWIN  = ((ROWS - K) / STRIDE + 1) * ((COLS - K) / STRIDE + 1);
   localparam int FIRST = (K - 1) * COLS + K;  // pixels accepted up to the first window

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b1;
   logic              in_valid  = 1'b0;
   logic              in_ready;
   logic [BD-1:0]     in_data   = '0;
   logic              flush     = 1'b0;
   logic              win_valid;
   logic              win_ready = 1'b1;
   logic [K*K*BD-1:0] win_data;
   logic [RW-1:0]     win_row;
   logic [CW-1:0]     win_col;
   logic              frame_done;

   window_linebuffer #(
      .BIT_DEPTH (BD),
      .COLS      (COLS),
      .ROWS      (ROWS),
      .K         (K)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .flush      (flush),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [K*K*BD-1:0] data;
      logic [RW-1:0]     row;
      logic [CW-1:0]     col;
   } exp_t;

   exp_t              q[$];
   logic [BD-1:0]     tl_log[$];
   logic [K*K*BD-1:0] first_data;
   logic [K*K*BD-1:0] last_data;
   int   checks  = 0;
   int   errors  = 0;
   int   win_cnt = 0;
   int   fd_cnt  = 0;
   int   cur_r   = 0;
   int   cur_c   = 0;
   logic exp_wv  = 1'b0;
   logic exp_fd  = 1'b0;

`ifdef WINDOW_LB_STRIDE2_EN
   int first_lit[9] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
   int last_lit[9]  = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
   int tl_lit[4]    = '{1, 3, 11, 13};
`else
   int first_lit[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
   int last_lit[9]  = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
   int tl_lit[4]    = '{1, 2, 5, 6};
`endif

   function automatic logic [BD-1:0] pix(input int r, input int c);
      return BD'(r * COLS + c + 1);
   endfunction

   function automatic exp_t make_exp(input int r0, input int c0);
      exp_t e;
      e.data = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) e.data[(r*K+c)*BD +: BD] = pix(r0 + r, c0 + c);
      end
      e.row = RW'(r0 / STRIDE);
      e.col = CW'(c0 / STRIDE);
      return e;
   endfunction

   function automatic logic [K*K*BD-1:0] pack_lit(input int lit[9]);
      logic [K*K*BD-1:0] v;
      v = '0;
      for (int i = 0; i < K*K; i++) v[i*BD +: BD] = BD'(lit[i]);
      return v;
   endfunction

   // Clean restart of DUT and model; returns at posedge+1.
   task automatic do_reset();
      in_valid  = 1'b0;
      flush     = 1'b0;
      win_ready = 1'b1;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n   = 1'b1;
      cur_r   = 0;
      cur_c   = 0;
      exp_wv  = 1'b0;
      exp_fd  = 1'b0;
      win_cnt = 0;
      fd_cnt  = 0;
      q.delete();
      tl_log.delete();
   endtask

   // Free-flowing stream of npix pixels with win_ready high; scoreboard consumer inline.
   // With drain set, keeps clocking until every expected window has been seen.
   task automatic stream(input int npix, input bit drain);
      int   sent  = 0;
      int   guard = 0;
      logic acc;
      logic emit;
      logic last;
      exp_t e;
      while ((sent < npix || (drain && q.size() != 0)) && guard < npix + 2*COLS + 20) begin
         guard++;
         in_valid  = (sent < npix);
         in_data   = pix(cur_r, cur_c);
         win_ready = 1'b1;
         #1;
         checks++;
         if (win_valid !== exp_wv) begin
            errors++;
            $display("FAIL win_valid at (%0d,%0d): got %b expected %b", cur_r, cur_c,
                     win_valid, exp_wv);
         end
         checks++;
         if (frame_done !== exp_fd) begin
            errors++;
            $display("FAIL frame_done at (%0d,%0d): got %b expected %b", cur_r, cur_c,
                     frame_done, exp_fd);
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready free-flow: got %b expected 1", in_ready);
         end
         if (frame_done === 1'b1) fd_cnt++;
         if (win_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected window: got row=%0d col=%0d expected none",
                        win_row, win_col);
            end else begin
               e = q.pop_front();
               if (win_data !== e.data || win_row !== e.row || win_col !== e.col) begin
                  errors++;
                  $display("FAIL window: got data=%h row=%0d col=%0d expected data=%h row=%0d col=%0d",
                           win_data, win_row, win_col, e.data, e.row, e.col);
               end
               if (win_cnt == 0) first_data = win_data;
               last_data = win_data;
               tl_log.push_back(win_data[BD-1:0]);
               win_cnt++;
            end
         end
         acc  = in_valid && in_ready;
         emit = 1'b0;
         last = 1'b0;
         if (acc === 1'b1) begin
            if (cur_r >= K-1 && cur_c >= K-1 &&
                (cur_r - (K-1)) % STRIDE == 0 && (cur_c - (K-1)) % STRIDE == 0) begin
               q.push_back(make_exp(cur_r - (K-1), cur_c - (K-1)));
               emit = 1'b1;
            end
            last = (cur_r == ROWS-1) && (cur_c == COLS-1);
            if (cur_c == COLS-1) begin
               cur_c = 0;
               cur_r = (cur_r == ROWS-1) ? 0 : cur_r + 1;
            end else begin
               cur_c++;
            end
            sent++;
         end
         exp_wv = emit;
         exp_fd = last;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (sent < npix || (drain && q.size() != 0)) begin
         checks++;
         errors++;
         $display("FAIL stream timeout: got sent=%0d pending=%0d expected sent=%0d pending=0",
                  sent, q.size(), npix);
      end
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_data !== '0 ||
          win_row !== '0 || win_col !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset state: got v=%b fd=%b data=%h row=%0d col=%0d rdy=%b expected all 0, rdy=1",
                  win_valid, frame_done, win_data, win_row, win_col, in_ready);
      end
      do_reset();
   endtask

   task automatic test_fill_and_frame();
      do_reset();
      stream(NPIX, 1'b1);
      checks++;
      if (win_cnt !== NWIN) begin
         errors++;
         $display("FAIL frame window count: got %0d expected %0d", win_cnt, NWIN);
      end
      checks++;
      if (fd_cnt !== 1) begin
         errors++;
         $display("FAIL frame_done count: got %0d expected 1", fd_cnt);
      end
      checks++;
      if (first_data !== pack_lit(first_lit)) begin
         errors++;
         $display("FAIL first window: got %h expected %h", first_data, pack_lit(first_lit));
      end
      checks++;
      if (last_data !== pack_lit(last_lit)) begin
         errors++;
         $display("FAIL last window: got %h expected %h", last_data, pack_lit(last_lit));
      end
      for (int i = 0; i < 4 && i < tl_log.size(); i++) begin
         checks++;
         if (tl_log[i] !== BD'(tl_lit[i])) begin
            errors++;
            $display("FAIL top-left %0d: got %0d expected %0d", i, tl_log[i], tl_lit[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      exp_t held;
      do_reset();
      stream(FIRST, 1'b0);
      held = q[0];
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'b1;
         in_data   = pix(cur_r, cur_c);
         win_ready = 1'b0;
         #1;
         checks++;
         if (in_ready !== 1'b0 || win_valid !== 1'b1 || win_data !== held.data ||
             win_row !== held.row || win_col !== held.col) begin
            errors++;
            $display("FAIL stall %0d: got rdy=%b v=%b data=%h expected rdy=0 v=1 data=%h",
                     i, in_ready, win_valid, win_data, held.data);
         end
         @(posedge clk);
         #1;
      end
      stream(NPIX - FIRST, 1'b1);
      checks++;
      if (win_cnt !== NWIN) begin
         errors++;
         $display("FAIL backpressure window count: got %0d expected %0d", win_cnt, NWIN);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      stream(2 * NPIX, 1'b1);
      checks++;
      if (win_cnt !== 2 * NWIN || fd_cnt !== 2) begin
         errors++;
         $display("FAIL two frames: got windows=%0d fd=%0d expected windows=%0d fd=2",
                  win_cnt, fd_cnt, 2 * NWIN);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      stream(7, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (win_valid !== 1'b0 || win_data !== '0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL async reset mid-frame: got v=%b data=%h fd=%b expected 0", win_valid,
                  win_data, frame_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cur_r   = 0;
      cur_c   = 0;
      exp_wv  = 1'b0;
      exp_fd  = 1'b0;
      win_cnt = 0;
      fd_cnt  = 0;
      q.delete();
      tl_log.delete();
      stream(NPIX, 1'b1);
      checks++;
      if (win_cnt !== NWIN || first_data !== pack_lit(first_lit)) begin
         errors++;
         $display("FAIL after reset: got windows=%0d first=%h expected windows=%0d first=%h",
                  win_cnt, first_data, NWIN, pack_lit(first_lit));
      end
   endtask

   task automatic test_flush();
      do_reset();
      stream(7, 1'b0);
      in_valid = 1'b1;
      in_data  = pix(cur_r, cur_c);
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL flush after pixel 7: got v=%b fd=%b expected 0", win_valid, frame_done);
      end
      cur_r   = 0;
      cur_c   = 0;
      exp_wv  = 1'b0;
      exp_fd  = 1'b0;
      win_cnt = 0;
      fd_cnt  = 0;
      stream(NPIX, 1'b1);
      checks++;
      if (win_cnt !== NWIN || fd_cnt !== 1 || first_data !== pack_lit(first_lit)) begin
         errors++;
         $display("FAIL after flush: got windows=%0d fd=%0d first=%h expected %0d 1 %h",
                  win_cnt, fd_cnt, first_data, NWIN, pack_lit(first_lit));
      end
      // Flush while a window is held: must clear it and drop the offered pixel.
      stream(FIRST, 1'b0);
      in_valid  = 1'b1;
      in_data   = pix(cur_r, cur_c);
      win_ready = 1'b0;
      flush     = 1'b1;
      #1;
      checks++;
      if (win_valid !== 1'b1) begin
         errors++;
         $display("FAIL pre-flush window: got v=%b expected 1", win_valid);
      end
      @(posedge clk);
      #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      win_ready = 1'b1;
      checks++;
      if (win_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush over held window: got v=%b expected 0", win_valid);
      end
      q.delete();
      cur_r   = 0;
      cur_c   = 0;
      exp_wv  = 1'b0;
      exp_fd  = 1'b0;
      win_cnt = 0;
      stream(NPIX, 1'b1);
      checks++;
      if (win_cnt !== NWIN) begin
         errors++;
         $display("FAIL after second flush: got windows=%0d expected %0d", win_cnt, NWIN);
      end
   endtask

   initial begin
      test_reset();
      test_fill_and_frame();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      test_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
